fp16_operand_unpack: RTL and testbench

FP16_OPERAND_UNPACK -- requirements
Module: fp16_operand_unpack

---
 rtl/fp16_operand_unpack_pkg.sv | 34 +++
 rtl/fp16_field_decode.sv | 42 ++++
 rtl/fp16_operand_unpack.sv | 102 ++++++++++
 tb/tb_fp16_operand_unpack.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_operand_unpack_pkg.sv
// Shared FP16 field geometry and the decoded-operand record used by the
// operand unpack block and its field decoder.
package fp16_operand_unpack_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = 11;
  localparam int FP16_W = SIGN_W + EXP_W + FRAC_W;
  localparam int BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = EXP_W'(2 * BIAS + 1);
  localparam logic [EXP_W-1:0] EXP_SUBNORM = 5'd1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             zero;
    logic             special;
  } fp16_dec_t;

  // Exponent an operand offers to the group max: zeros offer nothing.
  function automatic logic [EXP_W-1:0] grp_contrib(input fp16_dec_t d);
    logic [EXP_W-1:0] c;
    if (d.zero) begin
      c = '0;
    end else begin
      c = d.exp;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp16_field_decode.sv
// Pure combinational split of an FP16 word into sign, effective exponent,
// significand with explicit leading bit, and zero/special flags.
module fp16_field_decode
  import fp16_operand_unpack_pkg::*;
(
  input  logic [FP16_W-1:0] data,
  output fp16_dec_t         dec
);

  logic [EXP_W-1:0]  exp_field_s;
  logic [FRAC_W-1:0] frac_s;

  assign exp_field_s = data[FRAC_W +: EXP_W];
  assign frac_s      = data[FRAC_W-1:0];

  // Classify by exponent field; subnormals share the exponent of the smallest normal.
  always_comb begin
    dec         = '0;
    dec.sign    = data[FP16_W-1];
    case (exp_field_s)
      5'd0: begin
        dec.exp     = EXP_SUBNORM;
        dec.sig     = {1'b0, frac_s};
        dec.zero    = (frac_s == 10'd0);
        dec.special = 1'b0;
      end
      EXP_SPECIAL: begin
        dec.exp     = EXP_SPECIAL;
        dec.sig     = {1'b1, frac_s};
        dec.zero    = 1'b0;
        dec.special = 1'b1;
      end
      default: begin
        dec.exp     = exp_field_s;
        dec.sig     = {1'b1, frac_s};
        dec.zero    = 1'b0;
        dec.special = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp16_operand_unpack.sv
// Single-stage FP16 operand unpacker: decodes each accepted operand, tags the
// last operand of every GROUP_SIZE group and reports that group's max exponent.
module fp16_operand_unpack
  import fp16_operand_unpack_pkg::*;
#(
  parameter int GROUP_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SIG_W-1:0]  out_sig,
  output logic              out_zero,
  output logic              out_special,
  output logic              out_last,
  output logic [EXP_W:0]    out_grp_max_exp
);

  localparam int CNT_W = (GROUP_SIZE > 2) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP_SIZE - 1);

  fp16_dec_t        dec_s;
  logic             accept_s;
  logic             pop_s;
  logic             is_last_s;
  logic [EXP_W-1:0] contrib_s;
  logic [EXP_W-1:0] max_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [EXP_W-1:0] run_max_r;

  fp16_field_decode u_decode (
    .data (in_data),
    .dec  (dec_s)
  );

  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign is_last_s = (cnt_r == CNT_LAST);
  assign contrib_s = grp_contrib(dec_s);

  // Running max including the operand currently being offered.
  always_comb begin
    max_next_s = run_max_r;
    if (contrib_s > run_max_r) begin
      max_next_s = contrib_s;
    end else begin
      max_next_s = run_max_r;
    end
  end

  // Output register, group position counter and running max; a closing
  // operand reports the group max and restarts tracking in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_sign        <= 1'b0;
      out_exp         <= '0;
      out_sig         <= '0;
      out_zero        <= 1'b0;
      out_special     <= 1'b0;
      out_last        <= 1'b0;
      out_grp_max_exp <= '0;
      cnt_r           <= '0;
      run_max_r       <= '0;
    end else if (accept_s) begin
      out_valid   <= 1'b1;
      out_sign    <= dec_s.sign;
      out_exp     <= dec_s.exp;
      out_sig     <= dec_s.sig;
      out_zero    <= dec_s.zero;
      out_special <= dec_s.special;
      out_last    <= is_last_s;
      if (is_last_s) begin
        out_grp_max_exp <= {1'b0, max_next_s};
        cnt_r           <= '0;
        run_max_r       <= '0;
      end else begin
        out_grp_max_exp <= '0;
        cnt_r           <= cnt_r + CNT_W'(1);
        run_max_r       <= max_next_s;
      end
    end else if (pop_s) begin
      out_valid       <= 1'b0;
      out_sign        <= 1'b0;
      out_exp         <= '0;
      out_sig         <= '0;
      out_zero        <= 1'b0;
      out_special     <= 1'b0;
      out_last        <= 1'b0;
      out_grp_max_exp <= '0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// Self-checking bench for fp16_operand_unpack: directed decode/group/backpressure
// and reset scenarios plus randomized traffic against a behavioural model.
module tb_fp16_operand_unpack;

  localparam int GS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [10:0] out_sig;
  logic        out_zero;
  logic        out_special;
  logic        out_last;
  logic [5:0]  out_grp_max_exp;

  int total = 0;
  int bad = 0;

  // Behavioural model of what the output stage should be holding
  logic        m_valid = 1'b0;
  logic        m_sign = 1'b0;
  logic [4:0]  m_exp = 5'd0;
  logic [10:0] m_sig = 11'd0;
  logic        m_zero = 1'b0;
  logic        m_special = 1'b0;
  logic        m_last = 1'b0;
  logic [5:0]  m_gmax = 6'd0;
  int          grp_pos = 0;
  int          grp_q[$];

  logic [26:0] obs;
  logic [26:0] expv;
  assign obs  = {out_valid, out_sign, out_exp, out_sig, out_zero, out_special, out_last, out_grp_max_exp};
  assign expv = {m_valid, m_sign, m_exp, m_sig, m_zero, m_special, m_last, m_gmax};

  always #5 clk = ~clk;

  fp16_operand_unpack #(.GROUP_SIZE(GS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sign        (out_sign),
    .out_exp         (out_exp),
    .out_sig         (out_sig),
    .out_zero        (out_zero),
    .out_special     (out_special),
    .out_last        (out_last),
    .out_grp_max_exp (out_grp_max_exp)
  );

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Advance one clock, updating the model from the handshake about to happen.
  task automatic tick();
    logic acc;
    logic pop;
    int e, f, mx;
    acc = in_valid && (!m_valid || out_ready);
    pop = m_valid && out_ready;
    if (acc) begin
      e = int'(in_data[14:10]);
      f = int'(in_data[9:0]);
      m_valid   = 1'b1;
      m_sign    = in_data[15];
      m_exp     = (e == 0) ? 5'd1 : 5'(e);
      m_sig     = (e == 0) ? 11'(f) : 11'(f + 1024);
      m_zero    = (e == 0) && (f == 0);
      m_special = (e == 31);
      grp_q.push_back(m_zero ? 0 : int'(m_exp));
      m_last = (grp_pos == GS - 1);
      if (m_last) begin
        mx = 0;
        foreach (grp_q[i]) if (grp_q[i] > mx) mx = grp_q[i];
        m_gmax = 6'(mx);
        grp_q.delete();
        grp_pos = 0;
      end else begin
        m_gmax = 6'd0;
        grp_pos++;
      end
    end else if (pop) begin
      {m_valid, m_sign, m_exp, m_sig, m_zero, m_special, m_last, m_gmax} = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {m_valid, m_sign, m_exp, m_sig, m_zero, m_special, m_last, m_gmax} = '0;
    grp_pos = 0;
    grp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs !== 27'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs);
    end
    release_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_decode();
    drive(1'b1, 16'h3C00, 1'b1); tick();
    total++;
    if ({out_valid, out_exp, out_sig, out_sign, out_zero, out_last} !== {1'b1, 5'd15, 11'h400, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL normal_1p0 got=%b_%0d_%h_%b_%b_%b want=1_15_400_0_0_0", out_valid, out_exp, out_sig, out_sign, out_zero, out_last);
    end
    drive(1'b1, 16'h0001, 1'b1); tick();
    total++;
    if ({out_exp, out_sig, out_zero, out_special} !== {5'd1, 11'h001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL subnormal got=%0d_%h_%b_%b want=1_001_0_0", out_exp, out_sig, out_zero, out_special);
    end
    drive(1'b1, 16'h8000, 1'b1); tick();
    total++;
    if ({out_sign, out_zero, out_sig, out_exp} !== {1'b1, 1'b1, 11'h000, 5'd1}) begin
      bad++; $display("FAIL neg_zero got=%b_%b_%h_%0d want=1_1_000_1", out_sign, out_zero, out_sig, out_exp);
    end
    drive(1'b1, 16'h7C00, 1'b1); tick();
    total++;
    if ({out_special, out_exp, out_sig, out_last, out_grp_max_exp} !== {1'b1, 5'd31, 11'h400, 1'b1, 6'd31}) begin
      bad++; $display("FAIL special_group got=%b_%0d_%h_%b_%0d want=1_31_400_1_31", out_special, out_exp, out_sig, out_last, out_grp_max_exp);
    end
    drive(1'b0, 16'h0000, 1'b1); tick();
    total++;
    if ({out_valid, out_grp_max_exp} !== 7'd0) begin
      bad++; $display("FAIL drain_decode got=%b_%0d want=0_0", out_valid, out_grp_max_exp);
    end
  endtask

  task automatic test_group_max();
    logic [15:0] ops [4];
    ops[0] = 16'h3C00; ops[1] = 16'h0000; ops[2] = 16'h4800; ops[3] = 16'h3800;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 1'b1); tick();
      total++;
      if ({out_last, out_grp_max_exp} !== {(i == 3), (i == 3) ? 6'd18 : 6'd0}) begin
        bad++; $display("FAIL group_max_%0d got=%b_%0d want=%0d_%0d", i, out_last, out_grp_max_exp, (i == 3), (i == 3) ? 18 : 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0000, 1'b1); tick();
      total++;
      if ({out_zero, out_last, out_grp_max_exp} !== {1'b1, (i == 3), 6'd0}) begin
        bad++; $display("FAIL group_zero_%0d got=%b_%b_%0d want=1_%0d_0", i, out_zero, out_last, out_grp_max_exp, (i == 3));
      end
    end
    drive(1'b0, 16'h0000, 1'b1); tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h4000, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4400, 1'b0);
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready_%0d got=%b want=0", i, in_ready);
      end
      tick();
      total++;
      if ({out_valid, out_exp, out_sig} !== {1'b1, 5'd16, 11'h400}) begin
        bad++; $display("FAIL bp_hold_%0d got=%b_%0d_%h want=1_16_400", i, out_valid, out_exp, out_sig);
      end
    end
    drive(1'b1, 16'h4400, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready);
    end
    tick();
    total++;
    if ({out_valid, out_exp, out_sig} !== {1'b1, 5'd17, 11'h400}) begin
      bad++; $display("FAIL bp_reload got=%b_%0d_%h want=1_17_400", out_valid, out_exp, out_sig);
    end
    drive(1'b0, 16'h0000, 1'b1); tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_no_duplicate got=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    logic [15:0] ops [4];
    ops[0] = 16'h3C00; ops[1] = 16'h3C00; ops[2] = 16'h4000; ops[3] = 16'h3C00;
    drive(1'b1, 16'h5000, 1'b1); tick();
    drive(1'b1, 16'h5400, 1'b1); tick();
    apply_reset();
    total++;
    if (obs !== 27'd0) begin
      bad++; $display("FAIL midgrp_reset got=%h want=0", obs);
    end
    release_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 1'b1); tick();
      total++;
      if ({out_last, out_grp_max_exp} !== {(i == 3), (i == 3) ? 6'd16 : 6'd0}) begin
        bad++; $display("FAIL midgrp_pos_%0d got=%b_%0d want=%0d_%0d", i, out_last, out_grp_max_exp, (i == 3), (i == 3) ? 16 : 0);
      end
    end
    drive(1'b0, 16'h0000, 1'b1); tick();
  endtask

  task automatic test_random();
    logic        v, r, s;
    logic [31:0] rnd;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 3) != 0);
      rnd = $urandom();
      s   = rnd[31];
      case ($urandom_range(0, 4))
        0: d = {s, 15'h0000};
        1: d = {s, 5'd0, rnd[9:0]};
        2: d = {s, 5'd31, rnd[9:0]};
        default: d = rnd[15:0];
      endcase
      drive(v, d, r);
      total++;
      if (in_ready !== (!m_valid || r)) begin
        bad++; $display("FAIL rnd_in_ready_%0d got=%b want=%b", n, in_ready, (!m_valid || r));
      end
      tick();
      total++;
      if (m_valid) begin
        if (obs !== expv) begin
          bad++; $display("FAIL rnd_out_%0d got=%h want=%h", n, obs, expv);
        end
      end else if ({out_valid, out_grp_max_exp} !== 7'd0) begin
        bad++; $display("FAIL rnd_idle_%0d got=%b_%0d want=0_0", n, out_valid, out_grp_max_exp);
      end
    end
    drive(1'b0, 16'h0000, 1'b1); tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_group_max();
    test_backpressure();
    test_reset_mid_group();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
